// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch with a prefetch queue and redirect/drop handling.
// Defining FETCH_BYPASS_EN forwards an ack straight to the decoder when the queue is empty.
module fetch_sequencer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_inst,
   output logic [31:0] dec_pc,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc,
   input  logic        halt
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;
   state_t        state_q;
   logic          req_q;
   logic [31:0]   addr_q, pc_q;
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   pc_mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0]   cnt_q;
   logic          has_q, ack_ok, byp, push, pop, issue, unused_pc;
   assign unused_pc = ^redir_pc[1:0];
   assign has_q     = cnt_q != '0;
   assign ack_ok    = state_q == S_WAIT && imem_ack;
`ifdef FETCH_BYPASS_EN
   assign byp = ack_ok && !redir_valid && !has_q;
`else
   assign byp = 1'b0;
`endif
   assign pop       = has_q && dec_ready;
   assign push      = ack_ok && !redir_valid && !(byp && dec_ready);
   // count excludes the outstanding word, but issue only happens from IDLE, so full is the only bound
   assign issue     = state_q == S_IDLE && !halt && !redir_valid && !cnt_q[AW];
   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign dec_valid = byp || has_q;
   assign dec_inst  = byp ? imem_data : has_q ? inst_mem_q[rd_q] : '0;
   assign dec_pc    = byp ? addr_q : has_q ? pc_mem_q[rd_q] : '0;
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[wr_q] <= imem_data;
         pc_mem_q[wr_q]   <= addr_q;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
         pc_q    <= RESET_PC;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         if (issue) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
         end else if (imem_ack && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
         end else if (redir_valid && state_q == S_WAIT) begin
            state_q <= S_DROP;
         end
         if (redir_valid) begin
            pc_q  <= {redir_pc[31:2], 2'b00};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (ack_ok) pc_q <= pc_q + 32'd4;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch order, backpressure, redirects, halt, reset and bypass timing.
module tb_fetch_sequencer;
`ifdef FETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_ack, dec_valid, dec_ready, redir_valid, halt;
   logic [31:0] imem_addr, imem_data, dec_inst, dec_pc, redir_pc;
   logic        auto_ack = 1'b0, man_ack = 1'b0, en = 1'b1;
   logic [31:0] auto_data = '0, man_data = '0, exp_pc = '0;
   int          lat = 1, rcnt = 0, n_ack = 0, n_cmp = 0, n_err = 0, c = 0;

   fetch_sequencer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .dec_valid(dec_valid),
      .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
      .redir_valid(redir_valid), .redir_pc(redir_pc), .halt(halt)
   );

   always #5 clk = ~clk;
   assign imem_ack  = auto_ack | man_ack;
   assign imem_data = man_ack ? man_data : auto_data;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   always @(negedge clk) begin
      if (rst) n_ack = 0;
      if (rst || !en || auto_ack) begin
         auto_ack = 1'b0;
         rcnt = 0;
      end else if (imem_req) begin
         rcnt++;
         if (rcnt >= lat) begin
            auto_ack = 1'b1;
            auto_data = mem(imem_addr);
            n_ack++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic drain(input string tag, input int n, input int budget);
      int got = 0;
      for (int k = 0; k < budget && got < n; k++) begin
         @(negedge clk);
         #1;
         if (dec_valid && dec_ready) begin
            chk({tag, "_pc"}, dec_pc, exp_pc);
            chk({tag, "_inst"}, dec_inst, mem(exp_pc));
            exp_pc += 32'd4;
            got++;
         end
      end
      chk({tag, "_count"}, got, n);
   endtask

   initial begin
      dec_ready = 1'b1;
      redir_valid = 1'b0;
      redir_pc = '0;
      halt = 1'b0;
      tick;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", dec_valid, 0);
      chk("rst_inst", dec_inst, 0);
      chk("rst_pc", dec_pc, 0);
      do_reset;
      exp_pc = 32'h0;
      drain("t1", 4, 10);

      dec_ready = 1'b0;
      do_reset;
      repeat (20) tick;
      chk("t2_acks", n_ack, 4);
      chk("t2_req_idle", imem_req, 0);
      chk("t2_head_pc", dec_pc, 32'h0);
      dec_ready = 1'b1;
      exp_pc = 32'h0;
      drain("t2", 5, 20);

      lat = 3;
      do_reset;
      tick;
      chk("t3_req", imem_req, 1);
      chk("t3_addr0", imem_addr, 32'h0);
      redir_valid = 1'b1;
      redir_pc = 32'h1003;
      tick;
      redir_valid = 1'b0;
      chk("t3_drop_req", imem_req, 1);
      chk("t3_drop_addr", imem_addr, 32'h0);
      c = 0;
      while (imem_req && c < 20) begin tick; c++; end
      while (!imem_req && c < 20) begin tick; c++; end
      chk("t3_new_addr", imem_addr, 32'h1000);
      chk("t3_no_stale", dec_valid, 0);
      exp_pc = 32'h1000;
      drain("t3", 1, 15);

      lat = 1;
      dec_ready = 1'b0;
      do_reset;
      tick;
      tick;
      chk("t4_head_valid", dec_valid, 1);
      chk("t4_head_pc", dec_pc, 32'h0);
      tick;
      chk("t4_addr4", imem_addr, 32'h4);
      redir_valid = 1'b1;
      redir_pc = 32'h2000;
      dec_ready = 1'b1;
      tick;
      redir_valid = 1'b0;
      chk("t4_flush_valid", dec_valid, 0);
      chk("t4_flush_req", imem_req, 0);
      tick;
      chk("t4_new_req", imem_req, 1);
      chk("t4_new_addr", imem_addr, 32'h2000);
      exp_pc = 32'h2000;
      drain("t4", 1, 10);

      do_reset;
      redir_valid = 1'b1;
      redir_pc = 32'hFFFF_FFFF;
      tick;
      redir_valid = 1'b0;
      chk("wrap_no_req", imem_req, 0);
      tick;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      exp_pc = 32'hFFFF_FFFC;
      drain("wrap", 2, 10);

      lat = 3;
      dec_ready = 1'b0;
      do_reset;
      tick;
      halt = 1'b1;
      c = 0;
      while (!dec_valid && c < 10) begin tick; c++; end
      chk("t5_pushed_pc", dec_pc, 32'h0);
      repeat (5) tick;
      chk("t5_halt_req", imem_req, 0);
      chk("t5_halt_acks", n_ack, 1);
      halt = 1'b0;
      en = 1'b0;
      tick;
      chk("t5_resume_req", imem_req, 1);
      chk("t5_resume_addr", imem_addr, 32'h4);
      rst = 1'b1;
      tick;
      chk("t5_rst_req", imem_req, 0);
      chk("t5_rst_addr", imem_addr, 32'h0);
      chk("t5_rst_valid", dec_valid, 0);
      chk("t5_rst_inst", dec_inst, 0);
      chk("t5_rst_pc", dec_pc, 0);
      rst = 1'b0;
      man_ack = 1'b1;
      man_data = 32'h0BAD_0BAD;
      tick;
      man_ack = 1'b0;
      chk("t5_late_ack", dec_valid, 0);
      chk("t5_restart_req", imem_req, 1);
      chk("t5_restart_addr", imem_addr, 32'h0);
      en = 1'b1;
      lat = 1;
      dec_ready = 1'b1;
      exp_pc = 32'h0;
      drain("t5", 1, 10);

      do_reset;
      tick;
      @(negedge clk);
      #1;
      chk("t6_ack", imem_ack, 1);
      chk("t6_same_cycle", dec_valid, BYP);
      tick;
      chk("t6_next_cycle", dec_valid, !BYP);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
